acs_array: RTL and testbench

// - Add-compare-select stage of the Viterbi decoder, directly downstream of the bmc0..bmc7 branch-metric blocks.
// - Holds one registered path metric per trellis state.
// - Each accepted symbol: adds the two incoming branch metrics to the predecessor path metrics, keeps the smaller sum, and emits one survivor decision bit per state to the traceback stage.
// - Renormalises metrics so they never overflow.

---
 rtl/acs_array.sv | 117 +++++++++++
 tb/tb_acs_array.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/acs_array.sv
// Viterbi add-compare-select array: one registered path metric per trellis state, 1-cycle datapath.
// Optional best-state outputs are enabled with `define ACS_BEST_STATE_EN.
module acs_array #(
  parameter int NSTATES = 8,
  parameter int PM_W    = 6,
  parameter int INIT_PM = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [4*NSTATES-1:0]      bm_in,
  output logic                      out_valid,
  output logic [NSTATES-1:0]        dec,
  output logic [NSTATES*PM_W-1:0]   pm_flat,
  output logic [15:0]               sym_cnt,
  output logic                      renorm
`ifdef ACS_BEST_STATE_EN
  ,
  output logic [$clog2(NSTATES)-1:0] best_state,
  output logic [PM_W-1:0]            best_pm
`endif
);

  localparam int HALF = NSTATES / 2;
  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  logic [PM_W-1:0]    pm_q    [NSTATES];
  logic [PM_W-1:0]    base_pm [NSTATES];
  logic [PM_W:0]      cand0   [NSTATES];
  logic [PM_W:0]      cand1   [NSTATES];
  logic [PM_W:0]      sel_sum [NSTATES];
  logic [PM_W-1:0]    sel_pm  [NSTATES];
  logic [PM_W-1:0]    new_pm  [NSTATES];
  logic [NSTATES-1:0] new_dec;
  logic               all_high;

  // A start arriving with a symbol computes against the initial metrics, not the stored ones.
  always_comb begin
    all_high = 1'b1;
    new_dec  = '0;
    for (int s = 0; s < NSTATES; s++) begin
      base_pm[s] = start ? ((s == 0) ? '0 : INIT_V) : pm_q[s];
    end
    for (int s = 0; s < NSTATES; s++) begin
      cand0[s] = {1'b0, base_pm[s/2]}        + (PM_W+1)'(bm_in[4*s +: 2]);
      cand1[s] = {1'b0, base_pm[s/2 + HALF]} + (PM_W+1)'(bm_in[4*s+2 +: 2]);
      if (cand1[s] < cand0[s]) begin
        sel_sum[s] = cand1[s];
        new_dec[s] = 1'b1;
      end else begin
        sel_sum[s] = cand0[s];
      end
      // Renormalisation keeps sums in range; clipping only guards against misuse of parameters.
      sel_pm[s] = sel_sum[s][PM_W] ? '1 : sel_sum[s][PM_W-1:0];
      all_high  = all_high & sel_pm[s][PM_W-1];
    end
    for (int s = 0; s < NSTATES; s++) begin
      new_pm[s] = sel_pm[s];
      if (all_high) new_pm[s][PM_W-1] = 1'b0;
    end
  end

  always_comb begin
    pm_flat = '0;
    for (int s = 0; s < NSTATES; s++) begin
      pm_flat[PM_W*s +: PM_W] = pm_q[s];
    end
  end

`ifdef ACS_BEST_STATE_EN
  logic [$clog2(NSTATES)-1:0] best_idx;
  logic [PM_W-1:0]            best_val;

  // Strict less-than so the lowest index wins ties.
  always_comb begin
    best_idx = '0;
    best_val = new_pm[0];
    for (int s = 1; s < NSTATES; s++) begin
      if (new_pm[s] < best_val) begin
        best_val = new_pm[s];
        best_idx = ($clog2(NSTATES))'(s);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTATES; s++) pm_q[s] <= (s == 0) ? '0 : INIT_V;
      dec       <= '0;
      out_valid <= 1'b0;
      renorm    <= 1'b0;
      sym_cnt   <= '0;
`ifdef ACS_BEST_STATE_EN
      best_state <= '0;
      best_pm    <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      renorm    <= in_valid & all_high;
      if (in_valid) begin
        for (int s = 0; s < NSTATES; s++) pm_q[s] <= new_pm[s];
        dec     <= new_dec;
        sym_cnt <= start ? 16'd1 : sym_cnt + 16'd1;
`ifdef ACS_BEST_STATE_EN
        best_state <= best_idx;
        best_pm    <= best_val;
`endif
      end else if (start) begin
        for (int s = 0; s < NSTATES; s++) pm_q[s] <= (s == 0) ? '0 : INIT_V;
        sym_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_acs_array.sv
// Self-checking bench for acs_array: constant vector table, directed corner sequences and
// randomized traffic compared against an integer trellis model.
module tb_acs_array;

  localparam int NS   = 8;
  localparam int PW   = 6;
  localparam int INIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] bm_in = '0;
  logic        out_valid;
  logic [7:0]  dec;
  logic [47:0] pm_flat;
  logic [15:0] sym_cnt;
  logic        renorm;
`ifdef ACS_BEST_STATE_EN
  logic [2:0]  best_state;
  logic [5:0]  best_pm;
`endif

  always #5 clk = ~clk;

  acs_array #(.NSTATES(NS), .PM_W(PW), .INIT_PM(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .bm_in(bm_in),
    .out_valid(out_valid), .dec(dec), .pm_flat(pm_flat), .sym_cnt(sym_cnt), .renorm(renorm)
`ifdef ACS_BEST_STATE_EN
    , .best_state(best_state), .best_pm(best_pm)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: bounded metrics as stored, plus an unbounded copy with no renormalisation.
  int ref_pm  [NS];
  int ref_unb [NS];
  int ref_dec, ref_sym, ref_best, ref_best_pm;
  bit ref_ov, ref_ren;

  typedef struct {
    bit          r, st, v;
    logic [31:0] bm;
    bit          ov;
    logic [7:0]  dec;
    logic [47:0] pm;
    int          sym;
    bit          ren;
  } vec_t;

  vec_t tbl[7];

  function automatic int init_of(int s);
    return (s == 0) ? 0 : INIT;
  endfunction

  function automatic int bm_of(logic [31:0] bm, int s, int p);
    return int'(bm[4*s + 2*p +: 2]);
  endfunction

  function automatic logic [31:0] rand_bm();
    logic [31:0] b;
    for (int i = 0; i < 16; i++) b[2*i +: 2] = 2'($urandom_range(0, 2));
    return b;
  endfunction

  task automatic model_init();
    for (int s = 0; s < NS; s++) begin
      ref_pm[s]  = init_of(s);
      ref_unb[s] = init_of(s);
    end
  endtask

  task automatic model_cycle(bit r, bit st, bit v, logic [31:0] bm);
    int base[NS];
    int ubase[NS];
    int nw[NS];
    int unw[NS];
    int c0, c1, d;
    bit all_hi;
    if (!r) begin
      model_init();
      ref_dec = 0; ref_ov = 0; ref_ren = 0; ref_sym = 0;
      ref_best = 0; ref_best_pm = 0;
    end else if (v) begin
      d = 0;
      for (int s = 0; s < NS; s++) begin
        base[s]  = st ? init_of(s) : ref_pm[s];
        ubase[s] = st ? init_of(s) : ref_unb[s];
      end
      for (int s = 0; s < NS; s++) begin
        c0 = base[s/2] + bm_of(bm, s, 0);
        c1 = base[s/2 + NS/2] + bm_of(bm, s, 1);
        if (c1 < c0) begin
          nw[s] = c1;
          d = d | (1 << s);
        end else begin
          nw[s] = c0;
        end
        c0 = ubase[s/2] + bm_of(bm, s, 0);
        c1 = ubase[s/2 + NS/2] + bm_of(bm, s, 1);
        unw[s] = (c1 < c0) ? c1 : c0;
      end
      all_hi = 1'b1;
      for (int s = 0; s < NS; s++) if (nw[s] < 32) all_hi = 1'b0;
      if (all_hi) for (int s = 0; s < NS; s++) nw[s] = nw[s] - 32;
      ref_best = 0;
      ref_best_pm = nw[0];
      for (int s = 0; s < NS; s++) begin
        ref_pm[s]  = nw[s];
        ref_unb[s] = unw[s];
        if (nw[s] < ref_best_pm) begin
          ref_best_pm = nw[s];
          ref_best = s;
        end
      end
      ref_dec = d;
      ref_sym = st ? 1 : (ref_sym + 1) % 65536;
      ref_ov  = 1'b1;
      ref_ren = all_hi;
    end else begin
      ref_ov  = 1'b0;
      ref_ren = 1'b0;
      if (st) begin
        model_init();
        ref_sym = 0;
      end
    end
  endtask

  task automatic check_val(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, step the model at the rising edge, settle 1 time unit.
  task automatic applyStimulus(bit r, bit st, bit v, logic [31:0] bm);
    @(negedge clk);
    rst_n = r; start = st; in_valid = v; bm_in = bm;
    @(posedge clk);
    model_cycle(r, st, v, bm);
    #1;
  endtask

  task automatic checkOutput(string tag);
    check_val({tag, ".out_valid"}, int'(out_valid), int'(ref_ov));
    check_val({tag, ".dec"}, int'(dec), ref_dec);
    for (int s = 0; s < NS; s++) check_val($sformatf("%s.pm%0d", tag, s), int'(pm_flat[6*s +: 6]), ref_pm[s]);
    check_val({tag, ".sym_cnt"}, int'(sym_cnt), ref_sym);
    check_val({tag, ".renorm"}, int'(renorm), int'(ref_ren));
`ifdef ACS_BEST_STATE_EN
    check_val({tag, ".best_state"}, int'(best_state), ref_best);
    check_val({tag, ".best_pm"}, int'(best_pm), ref_best_pm);
`endif
  endtask

  initial begin
    logic [47:0] pm_init, pm_a, pm_b;
    int ren_pulses;

    pm_init = {{7{6'd16}}, 6'd0};
    pm_a    = {{6{6'd16}}, 6'd0, 6'd0};
    pm_b    = {6'd16, 6'd16, 6'd16, 6'd16, 6'd0, 6'd2, 6'd0, 6'd0};

    tbl[0] = '{r:0, st:0, v:0, bm:32'h0,        ov:0, dec:8'h00, pm:pm_init, sym:0, ren:0};
    tbl[1] = '{r:1, st:0, v:1, bm:32'h0,        ov:1, dec:8'h00, pm:pm_a,    sym:1, ren:0};
    tbl[2] = '{r:1, st:0, v:0, bm:32'h0,        ov:0, dec:8'h00, pm:pm_a,    sym:1, ren:0};
    tbl[3] = '{r:1, st:1, v:0, bm:32'h0,        ov:0, dec:8'h00, pm:pm_init, sym:0, ren:0};
    tbl[4] = '{r:1, st:0, v:1, bm:32'h0000_0200, ov:1, dec:8'h04, pm:pm_a,   sym:1, ren:0};
    tbl[5] = '{r:1, st:1, v:1, bm:32'h0,        ov:1, dec:8'h00, pm:pm_a,    sym:1, ren:0};
    tbl[6] = '{r:1, st:0, v:1, bm:32'h0000_0200, ov:1, dec:8'h00, pm:pm_b,   sym:2, ren:0};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].bm);
      check_val($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(tbl[i].ov));
      check_val($sformatf("vec%0d.dec", i), int'(dec), int'(tbl[i].dec));
      for (int s = 0; s < NS; s++)
        check_val($sformatf("vec%0d.pm%0d", i, s), int'(pm_flat[6*s +: 6]), int'(tbl[i].pm[6*s +: 6]));
      check_val($sformatf("vec%0d.sym_cnt", i), int'(sym_cnt), tbl[i].sym);
      check_val($sformatf("vec%0d.renorm", i), int'(renorm), int'(tbl[i].ren));
    end

    // Uniform branch metrics drive every metric past the half-range point exactly once.
    applyStimulus(0, 0, 0, 32'h0);
    ren_pulses = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 0, 1, 32'hAAAA_AAAA);
      checkOutput("renorm_seq");
      ren_pulses += int'(renorm);
      for (int s = 1; s < NS; s++)
        check_val($sformatf("renorm_diff%0d", s),
                  int'(pm_flat[6*s +: 6]) - int'(pm_flat[5:0]), ref_unb[s] - ref_unb[0]);
    end
    check_val("renorm_pulse_count", ren_pulses, 1);
    for (int s = 0; s < NS; s++) check_val($sformatf("renorm_below_half%0d", s), int'(pm_flat[6*s+5]), 0);

    // Restart mid-frame, with and without a symbol in the same cycle.
    applyStimulus(0, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 1, rand_bm());
    check_val("mid.sym_before", int'(sym_cnt), 5);
    applyStimulus(1, 1, 1, 32'h0);
    checkOutput("mid.start_valid");
    check_val("mid.pm_initial_based", int'(pm_flat == pm_a), 1);
    check_val("mid.sym_after", int'(sym_cnt), 1);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 1, rand_bm());
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("mid.start_only");
    check_val("mid.start_only_ov", int'(out_valid), 0);
    check_val("mid.start_only_sym", int'(sym_cnt), 0);

    // Reset pulse while symbols are streaming.
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 1, rand_bm());
    applyStimulus(0, 0, 1, rand_bm());
    checkOutput("rst_mid");
    check_val("rst_mid.dec", int'(dec), 0);
    check_val("rst_mid.pm_init", int'(pm_flat == pm_init), 1);
    applyStimulus(1, 0, 1, 32'h0);
    checkOutput("rst_resume");
    check_val("rst_resume.pm", int'(pm_flat == pm_a), 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) < 7, rand_bm());
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
